// File: rtl/abr_prim_reg_slice.sv
// abr_prim_reg_slice
//
// Fully registered valid/ready pipeline slice with a one-entry skid buffer.
// It cuts the forward (valid/data) and backward (ready) combinational paths
// between two streaming stages and still sustains one transfer per cycle.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   clear_i      synchronous flush, empties the slice (data registers hold)
//   in_valid_i   upstream data valid
//   in_ready_o   slice can accept (registered)
//   in_data_i    upstream payload
//   out_valid_o  main register holds valid data (registered)
//   out_ready_i  downstream accepts
//   out_data_o   main register payload
//   count_o      occupancy 0..2
module abr_prim_reg_slice #(
    parameter int unsigned           Width      = 32,
    parameter logic [Width-1:0]      ResetValue = '0,
    parameter bit                    EnSecBuf   = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o,
    output logic [1:0]       count_o
);

    // State encoding is {skid_valid, main_valid}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [Width-1:0]   main_data_q, main_data_d;
    logic [Width-1:0]   skid_data_q, skid_data_d;

    logic               in_xfer, out_xfer;
    logic               main_en_raw, skid_en_raw;
    logic               main_en, skid_en;
    logic               main_from_skid;

    // in_ready_q is a flop, so the input handshake never sees out_ready_i
    // combinationally.
    assign in_xfer  = in_valid_i && in_ready_q;
    assign out_xfer = state_q[0] && out_ready_i;

    // Next state and data-register enables.
    always_comb begin
        state_d        = state_q;
        main_en_raw    = 1'b0;
        skid_en_raw    = 1'b0;
        main_from_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    main_en_raw = 1'b1;
                    state_d     = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    // Simultaneous push/pop keeps full throughput.
                    main_en_raw = 1'b1;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end else if (in_xfer) begin
                    // Downstream stalled: park the new beat in the skid entry.
                    skid_en_raw = 1'b1;
                    state_d     = FULL;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_en_raw    = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush drops both entries; any input beat this cycle is lost and the
        // data registers keep whatever they held.
        if (clear_i) begin
            state_d     = EMPTY;
            main_en_raw = 1'b0;
            skid_en_raw = 1'b0;
        end
    end

    // Capture-enable anchoring point. Both variants are functionally a wire;
    // EnSecBuf marks where a hardening buffer is placed on the enables.
    if (EnSecBuf) begin : g_sec_buf
        logic [1:0] en_buf;
        assign en_buf  = {skid_en_raw, main_en_raw};
        assign main_en = en_buf[0];
        assign skid_en = en_buf[1];
    end else begin : g_no_sec_buf
        assign main_en = main_en_raw;
        assign skid_en = skid_en_raw;
    end

    always_comb begin
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (main_en) main_data_d = main_from_skid ? skid_data_q : in_data_i;
        if (skid_en) skid_data_d = in_data_i;
        // Ready is computed from the next skid-valid so it is registered.
        in_ready_d = !state_d[1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            main_data_q <= ResetValue;
            skid_data_q <= ResetValue;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = state_q[0];
    assign out_data_o  = main_data_q;
    assign count_o     = state_q[1] ? 2'd2 : (state_q[0] ? 2'd1 : 2'd0);

`ifndef SYNTHESIS
    property p_no_illegal_state;
        @(posedge clk_i) disable iff (rst_i) state_q != 2'b10;
    endproperty
    property p_out_stable;
        @(posedge clk_i) disable iff (rst_i)
            (out_valid_o && !out_ready_i) |=> $stable(out_data_o);
    endproperty
    property p_count_range;
        @(posedge clk_i) disable iff (rst_i) count_o != 2'd3;
    endproperty
    a_no_illegal_state: assert property (p_no_illegal_state);
    a_out_stable:       assert property (p_out_stable);
    a_count_range:      assert property (p_count_range);
`endif

endmodule

// File: tb/tb_abr_prim_reg_slice.sv
// Directed self-checking bench for abr_prim_reg_slice.
module tb_abr_prim_reg_slice;

    localparam int W = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          clear_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [W-1:0]  in_data_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [W-1:0]  out_data_o;
    logic [1:0]    count_o;

    int tests = 0;
    int fails = 0;

    abr_prim_reg_slice #(.Width(W), .ResetValue('0), .EnSecBuf(1'b0)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (clear_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .count_o     (count_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic v, input logic [W-1:0] d,
                           input logic r, input logic [1:0] c);
        chk({tag, ".valid"}, {31'd0, out_valid_o}, {31'd0, v});
        chk({tag, ".data"},  out_data_o, d);
        chk({tag, ".ready"}, {31'd0, in_ready_o}, {31'd0, r});
        chk({tag, ".count"}, {30'd0, count_o}, {30'd0, c});
    endtask

    initial begin
        rst_i       = 1'b1;
        clear_i     = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'hAAAA_5555;
        out_ready_i = 1'b0;

        // Reset held with a valid input: nothing is taken.
        step();
        step();
        chk_all("reset", 1'b0, 32'h0, 1'b1, 2'd0);

        // First edge after release captures the held beat.
        rst_i = 1'b0;
        step();
        chk_all("post_reset", 1'b1, 32'hAAAA_5555, 1'b1, 2'd1);

        // Drain; data register holds after pop.
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        step();
        chk_all("drain", 1'b0, 32'hAAAA_5555, 1'b1, 2'd0);

        // Streaming 1..8 back-to-back with 1-cycle latency.
        for (int i = 1; i <= 8; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = i;
            step();
            chk_all($sformatf("stream%0d", i), 1'b1, i, 1'b1, 2'd1);
        end
        in_valid_i = 1'b0;
        step();
        chk_all("stream_end", 1'b0, 32'd8, 1'b1, 2'd0);

        // Backpressure: push 0x11, 0x22 with downstream stalled.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'h11;
        step();
        chk_all("bp_one", 1'b1, 32'h11, 1'b1, 2'd1);
        in_data_i = 32'h22;
        step();
        chk_all("bp_full", 1'b1, 32'h11, 1'b0, 2'd2);
        in_data_i = 32'h33;
        step();
        chk_all("bp_hold", 1'b1, 32'h11, 1'b0, 2'd2);

        // FULL with 0x33 offered: 0x11 leaves, 0x33 is refused this cycle.
        out_ready_i = 1'b1;
        step();
        chk_all("full_pop", 1'b1, 32'h22, 1'b1, 2'd1);
        step();
        chk_all("take_33", 1'b1, 32'h33, 1'b1, 2'd1);
        in_valid_i = 1'b0;
        step();
        chk_all("drain_33", 1'b0, 32'h33, 1'b1, 2'd0);

        // Flush in FULL with a competing input 0x44.
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        in_data_i   = 32'h55;
        step();
        in_data_i = 32'h66;
        step();
        chk_all("pre_clear", 1'b1, 32'h55, 1'b0, 2'd2);
        clear_i   = 1'b1;
        in_data_i = 32'h44;
        step();
        chk_all("clear", 1'b0, 32'h55, 1'b1, 2'd0);
        clear_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        step();
        chk_all("after_clear", 1'b0, 32'h55, 1'b1, 2'd0);

        // Clear in ONE together with an input beat: beat discarded.
        in_valid_i = 1'b1;
        in_data_i  = 32'h99;
        out_ready_i = 1'b0;
        step();
        chk_all("one_99", 1'b1, 32'h99, 1'b1, 2'd1);
        clear_i   = 1'b1;
        in_data_i = 32'hAB;
        step();
        chk_all("clear_one", 1'b0, 32'h99, 1'b1, 2'd0);
        clear_i    = 1'b0;
        in_valid_i = 1'b0;

        // Mid-operation reset in FULL.
        in_valid_i = 1'b1;
        in_data_i  = 32'h77;
        step();
        in_data_i = 32'h88;
        step();
        chk_all("pre_reset", 1'b1, 32'h77, 1'b0, 2'd2);
        in_valid_i = 1'b0;
        rst_i      = 1'b1;
        step();
        chk_all("mid_reset", 1'b0, 32'h0, 1'b1, 2'd0);
        rst_i       = 1'b0;
        out_ready_i = 1'b1;
        step();
        chk_all("no_stale1", 1'b0, 32'h0, 1'b1, 2'd0);
        step();
        chk_all("no_stale2", 1'b0, 32'h0, 1'b1, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
